// File: rtl/shift_sequencer.sv
// Multi-cycle shift unit: accepts one SLL/SRL/SRA request and shifts a registered
// accumulator by up to STEP bits per cycle, pulsing done when the amount is used up.
module shift_sequencer #(
  parameter int unsigned STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operand,
  input  logic [4:0]  amount,
  input  logic        flush,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam int unsigned W  = 32;
  localparam int unsigned AW = 5;
  localparam logic [AW-1:0] STEP_AMT = AW'(STEP);

  if (STEP != 1 && STEP != 2 && STEP != 4 && STEP != 8 && STEP != 16) begin : g_bad_step
    $error("shift_sequencer: STEP must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [AW-1:0] rem_q, rem_d;
  logic [1:0]    op_q, op_d;
  logic          sign_q, sign_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [AW-1:0] step_c;
  logic [W-1:0]  fill_c;
  logic [W-1:0]  shifted_c;

  // Per-cycle step shifter: amount is min(STEP, rem), so never more than STEP.
  always_comb begin
    step_c    = (rem_q < STEP_AMT) ? rem_q : STEP_AMT;
    fill_c    = sign_q ? ~({W{1'b1}} >> step_c) : '0;
    shifted_c = acc_q >> step_c;
    case (op_q)
      2'b00:   shifted_c = acc_q << step_c;
      2'b11:   shifted_c = (acc_q >> step_c) | fill_c;
      default: shifted_c = acc_q >> step_c;
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    op_d    = op_q;
    sign_d  = sign_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          acc_d   = operand;
          rem_d   = amount;
          op_d    = op;
          sign_d  = operand[W-1];
          state_d = (amount == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        // A flushed operation is abandoned; the accumulator is left untouched.
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = shifted_c;
          rem_d = rem_q - step_c;
          if (rem_q == step_c) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Status flags are registered copies of the next-state decode.
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      op_q    <= 2'b00;
      sign_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ready  = ready_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = acc_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: three instances (STEP 1, 2, 4) share stimulus and are
// checked against an arithmetic model of the shift result and cycle timing.
module tb_shift_sequencer;

  localparam int B2B_LEN = 100;
  localparam int OBS_MAX = 64;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [1:0]  op;
  logic [31:0] operand;
  logic [4:0]  amount;
  logic        rdy [3];
  logic        bsy [3];
  logic        dn  [3];
  logic [31:0] res [3];

  int vectors = 0;
  int miscompares = 0;

  int          got_dcyc [3];
  int          got_rcyc [3];
  int          got_bcnt [3];
  int          got_dn   [3];
  logic [31:0] got_res  [3];

  logic [1:0]  b_op  [B2B_LEN];
  logic [31:0] b_dat [B2B_LEN];
  logic [4:0]  b_amt [B2B_LEN];
  int          obs_c [3][OBS_MAX];
  logic [31:0] obs_r [3][OBS_MAX];
  int          obs_n [3];

  always #5 clk = ~clk;

  shift_sequencer #(.STEP(1)) u_s1 (
    .clk(clk), .rst(rst), .start(start), .op(op), .operand(operand), .amount(amount),
    .flush(flush), .ready(rdy[0]), .busy(bsy[0]), .done(dn[0]), .result(res[0]));
  shift_sequencer #(.STEP(2)) u_s2 (
    .clk(clk), .rst(rst), .start(start), .op(op), .operand(operand), .amount(amount),
    .flush(flush), .ready(rdy[1]), .busy(bsy[1]), .done(dn[1]), .result(res[1]));
  shift_sequencer #(.STEP(4)) u_s4 (
    .clk(clk), .rst(rst), .start(start), .op(op), .operand(operand), .amount(amount),
    .flush(flush), .ready(rdy[2]), .busy(bsy[2]), .done(dn[2]), .result(res[2]));

  function automatic int step_of(input int k);
    return 1 << k;
  endfunction

  // Architectural 32-bit shift; op 10 behaves as SRL.
  function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] d,
                                            input logic [4:0] a);
    case (o)
      2'b00:   return d << a;
      2'b11:   return 32'($signed(d) >>> a);
      default: return d >> a;
    endcase
  endfunction

  function automatic int n_of(input int k, input logic [4:0] a);
    return (int'(a) + step_of(k) - 1) / step_of(k);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one request from an idle state and record what each instance does over
  // the next 40 cycles; cycle 0 is the request cycle.
  task automatic run_req(input logic [1:0] o, input logic [31:0] d, input logic [4:0] a);
    for (int k = 0; k < 3; k++) begin
      got_dcyc[k] = -1; got_rcyc[k] = -1; got_bcnt[k] = 0; got_dn[k] = 0; got_res[k] = '0;
    end
    start = 1'b1; op = o; operand = d; amount = a;
    tick();
    start = 1'b0; op = 2'($urandom); operand = $urandom; amount = 5'($urandom);
    for (int c = 1; c <= 40; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (bsy[k]) got_bcnt[k]++;
        if (dn[k]) begin
          got_dn[k]++;
          if (got_dcyc[k] == -1) begin
            got_dcyc[k] = c;
            got_res[k]  = res[k];
          end
        end
        if (rdy[k] && got_dcyc[k] != -1 && got_rcyc[k] == -1) got_rcyc[k] = c;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; operand = '0; amount = '0;
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if ({rdy[k], bsy[k], dn[k]} !== 3'b100) begin
        miscompares++;
        $display("FAIL reset_flags step%0d: rdy/bsy/dn=%b%b%b want 100", step_of(k), rdy[k], bsy[k], dn[k]);
      end
      vectors++;
      if (res[k] !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_result step%0d: got %h want 00000000", step_of(k), res[k]);
      end
    end
  endtask

  task automatic test_sra;
    run_req(2'b11, 32'h8000_0000, 5'd4);
    vectors++;
    if (got_dcyc[0] !== 5) begin
      miscompares++; $display("FAIL sra_latency: got %0d want 5", got_dcyc[0]);
    end
    vectors++;
    if (got_bcnt[0] !== 5) begin
      miscompares++; $display("FAIL sra_busy_cycles: got %0d want 5", got_bcnt[0]);
    end
    vectors++;
    if (got_res[0] !== 32'hF800_0000) begin
      miscompares++; $display("FAIL sra_result: got %h want f8000000", got_res[0]);
    end
    vectors++;
    if (got_rcyc[0] !== 6) begin
      miscompares++; $display("FAIL sra_ready_return: got %0d want 6", got_rcyc[0]);
    end
  endtask

  task automatic test_sll;
    run_req(2'b00, 32'h0000_0001, 5'd31);
    vectors++;
    if (got_dcyc[2] !== 9) begin
      miscompares++; $display("FAIL sll_latency_step4: got %0d want 9", got_dcyc[2]);
    end
    vectors++;
    if (got_res[2] !== 32'h8000_0000) begin
      miscompares++; $display("FAIL sll_result_step4: got %h want 80000000", got_res[2]);
    end
    vectors++;
    if (got_dcyc[0] !== 32) begin
      miscompares++; $display("FAIL sll_latency_step1: got %0d want 32", got_dcyc[0]);
    end
    run_req(2'b00, 32'h1234_5678, 5'd0);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (got_dcyc[k] !== 1) begin
        miscompares++; $display("FAIL zero_amount_latency step%0d: got %0d want 1", step_of(k), got_dcyc[k]);
      end
      vectors++;
      if (got_res[k] !== 32'h1234_5678) begin
        miscompares++; $display("FAIL zero_amount_result step%0d: got %h want 12345678", step_of(k), got_res[k]);
      end
    end
  endtask

  task automatic test_srl;
    logic [1:0] ops [2];
    ops[0] = 2'b01; ops[1] = 2'b10;
    for (int i = 0; i < 2; i++) begin
      run_req(ops[i], 32'hFFFF_FFFF, 5'd31);
      vectors++;
      if (got_res[1] !== 32'h0000_0001) begin
        miscompares++; $display("FAIL srl_result op%b: got %h want 00000001", ops[i], got_res[1]);
      end
      vectors++;
      if (got_dcyc[1] !== 17 || got_dn[1] !== 1) begin
        miscompares++; $display("FAIL srl_done op%b: cycle %0d count %0d want 17/1", ops[i], got_dcyc[1], got_dn[1]);
      end
    end
  endtask

  task automatic test_flush;
    int dseen [3];
    logic [1:0] o; logic [31:0] d; logic [4:0] a;
    start = 1'b1; flush = 1'b1; op = 2'b00; operand = 32'h1; amount = 5'd3;
    tick();
    start = 1'b0; flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (bsy[k] !== 1'b0 || rdy[k] !== 1'b1) begin
        miscompares++; $display("FAIL flush_blocks_accept step%0d: busy %b ready %b want 0/1", step_of(k), bsy[k], rdy[k]);
      end
      dseen[k] = 0;
    end
    start = 1'b1; op = 2'b11; operand = 32'h8000_0000 | $urandom; amount = 5'd20;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) if (dn[k]) dseen[k]++;
    tick();
    flush = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (dn[k]) dseen[k]++;
      vectors++;
      if (bsy[k] !== 1'b1) begin
        miscompares++; $display("FAIL flush_pre_busy step%0d: got %b want 1", step_of(k), bsy[k]);
      end
    end
    tick();
    flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (dn[k]) dseen[k]++;
      vectors++;
      if ({rdy[k], bsy[k]} !== 2'b10 || dseen[k] !== 0) begin
        miscompares++;
        $display("FAIL flush_abort step%0d: ready %b busy %b dones %0d want 1/0/0", step_of(k), rdy[k], bsy[k], dseen[k]);
      end
    end
    o = 2'($urandom); d = $urandom; a = 5'($urandom);
    run_req(o, d, a);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (got_dcyc[k] !== n_of(k, a) + 1 || got_res[k] !== ref_shift(o, d, a)) begin
        miscompares++;
        $display("FAIL flush_next_req step%0d: cycle %0d result %h want %0d/%h",
                 step_of(k), got_dcyc[k], got_res[k], n_of(k, a) + 1, ref_shift(o, d, a));
      end
    end
  endtask

  task automatic test_reset_mid;
    int dseen [3];
    start = 1'b1; op = 2'b11; operand = 32'h9ABC_DEF0; amount = 5'd20;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1; flush = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0; start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if ({rdy[k], bsy[k], dn[k]} !== 3'b100 || res[k] !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_mid step%0d: rdy/bsy/dn=%b%b%b result %h want 100/00000000",
                 step_of(k), rdy[k], bsy[k], dn[k], res[k]);
      end
      dseen[k] = 0;
    end
    for (int c = 0; c < 35; c++) begin
      for (int k = 0; k < 3; k++) if (dn[k]) dseen[k]++;
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (dseen[k] !== 0) begin
        miscompares++; $display("FAIL reset_mid_no_done step%0d: got %0d dones want 0", step_of(k), dseen[k]);
      end
    end
  endtask

  task automatic test_random;
    logic [1:0] o; logic [31:0] d; logic [4:0] a;
    logic [31:0] exp_r; int n;
    for (int it = 0; it < 20; it++) begin
      o = 2'($urandom); d = $urandom;
      a = (it == 0) ? 5'd31 : (it == 1) ? 5'd0 : 5'($urandom);
      run_req(o, d, a);
      exp_r = ref_shift(o, d, a);
      for (int k = 0; k < 3; k++) begin
        n = n_of(k, a);
        vectors++;
        if (got_dcyc[k] !== n + 1 || got_dn[k] !== 1) begin
          miscompares++;
          $display("FAIL rand_timing step%0d op%b amt%0d: done cycle %0d count %0d want %0d/1",
                   step_of(k), o, a, got_dcyc[k], got_dn[k], n + 1);
        end
        vectors++;
        if (got_res[k] !== exp_r || res[k] !== exp_r) begin
          miscompares++;
          $display("FAIL rand_result step%0d op%b d=%h amt%0d: got %h held %h want %h",
                   step_of(k), o, d, a, got_res[k], res[k], exp_r);
        end
        vectors++;
        if (got_bcnt[k] !== n + 1 || got_rcyc[k] !== n + 2) begin
          miscompares++;
          $display("FAIL rand_busy step%0d: busy cycles %0d ready at %0d want %0d/%0d",
                   step_of(k), got_bcnt[k], got_rcyc[k], n + 1, n + 2);
        end
      end
    end
  endtask

  // start held high with a fresh request every cycle: each instance takes a new
  // request n+2 cycles after the previous one, and start elsewhere is dropped.
  task automatic test_back_to_back;
    int c, idx, n;
    for (int k = 0; k < 3; k++) obs_n[k] = 0;
    for (int t = 0; t < B2B_LEN + 40; t++) begin
      for (int k = 0; k < 3; k++) begin
        if (dn[k]) begin
          if (obs_n[k] < OBS_MAX) begin
            obs_c[k][obs_n[k]] = t;
            obs_r[k][obs_n[k]] = res[k];
          end
          obs_n[k]++;
        end
      end
      if (t < B2B_LEN) begin
        start = 1'b1; op = 2'($urandom); operand = $urandom; amount = 5'($urandom);
        b_op[t] = op; b_dat[t] = operand; b_amt[t] = amount;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      c = 0; idx = 0;
      while (c < B2B_LEN) begin
        n = n_of(k, b_amt[c]);
        vectors++;
        if (idx >= obs_n[k] || idx >= OBS_MAX) begin
          miscompares++; $display("FAIL b2b_missing step%0d: request %0d no done seen", step_of(k), idx);
        end else if (obs_c[k][idx] !== c + n + 1 || obs_r[k][idx] !== ref_shift(b_op[c], b_dat[c], b_amt[c])) begin
          miscompares++;
          $display("FAIL b2b step%0d req%0d: cycle %0d result %h want %0d/%h", step_of(k), idx,
                   obs_c[k][idx], obs_r[k][idx], c + n + 1, ref_shift(b_op[c], b_dat[c], b_amt[c]));
        end
        idx++;
        c += n + 2;
      end
      vectors++;
      if (obs_n[k] !== idx) begin
        miscompares++; $display("FAIL b2b_done_count step%0d: got %0d want %0d", step_of(k), obs_n[k], idx);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sra();
    test_sll();
    test_srl();
    test_flush();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift unit controller for the execute stage. Accepts one shift request (SLL/SRL/SRA), walks the shift amount down in fixed-size steps on a registered accumulator, and signals completion with a one-cycle `done` pulse. Lets the core replace the combinational variable shifter with a small per-cycle step shifter, with the pipeline stalling on `busy`.

## Interface

Parameters:
- `STEP`, default 1: bits shifted per cycle. Legal values are 1, 2, 4, 8, 16; any other value is a configuration error.

Ports (name, direction, width, meaning):
- `clk` input 1: clock. Every state change happens on the rising edge.
- `rst` input 1: reset. One clock; reset is synchronous and active-high.
- `start` input 1: request strobe. Sampled only when `ready`=1.
- `op` input 2: shift operation. 00 = SLL, 01 = SRL, 11 = SRA, 10 = reserved (executes as SRL).
- `operand` input 32: value to be shifted.
- `amount` input 5: shift amount, 0–31.
- `flush` input 1: synchronous abort of any in-flight operation.
- `ready` output 1: high in IDLE. The block accepts a request only when `ready`=1.
- `busy` output 1: high in SHIFT and DONE. The pipeline uses it to stall.
- `done` output 1: one-cycle completion pulse.
- `result` output 32: accumulator value. Valid while `done`=1; holds that value until the next accepted request.

## Operation

- States are IDLE, SHIFT and DONE. State, accumulator, remaining count, latched op and latched sign bit are all registers.
- **Accept:** a request is accepted at a rising edge when state = IDLE, `start`=1 and `flush`=0. On accept the block:
  - loads `acc` with `operand`;
  - loads `rem` with `amount`;
  - latches `op`;
  - latches `sign` with `operand[31]`.
- **Accept transition:** goes to DONE if `amount`=0, otherwise to SHIFT.
- **SHIFT, each edge:**
  - s = min(`STEP`, `rem`);
  - `acc` is shifted by s: SLL fills with zeros, SRL fills with zeros, SRA fills with the latched `sign`;
  - `rem` becomes `rem` − s;
  - if `rem` − s = 0, go to DONE, otherwise stay in SHIFT.
- **DONE:** `done`=1 for exactly one cycle, then unconditionally to IDLE on the next edge.
- **`start` outside IDLE:** ignored; it is not queued.
- **Width rules:**
  - `rem` is 5 bits and never underflows, because s ≤ `rem`.
  - The step shifter only ever shifts by 0..`STEP`.
  - The result must equal the architectural 32-bit shift of `operand` by `amount`.
- **Flush:** `flush`=1 in SHIFT or DONE forces IDLE on the next edge.
  - A flush in SHIFT produces no `done` pulse.
  - A flush in DONE does not suppress the `done` already being driven that cycle.
  - `flush` together with `start` in IDLE means the request is not accepted.
- **Priority:** `rst` > `flush` > normal operation.
- **Reset values:**
  - state = IDLE, so `ready`=1, `busy`=0, `done`=0;
  - `result`/`acc` = 0, `rem` = 0, `sign` = 0, latched op = 00.
- **Reset mid-operation:** the operation is abandoned with no `done` pulse. Outputs take the reset values after the reset edge.
- **Output decode:** `ready`, `busy` and `done` are decoded from state only; there are no combinational paths from the inputs.

## Timing

- Let n = ceil(`amount` / `STEP`).
- **Accept edge E0:** the edge where `start`=1 and `ready`=1.
- **Shift edges:** E1..En perform the shifts. `done` is high in the cycle after En (after E0 when n = 0).
- **Latency:** n+1 cycles from the request cycle to the `done` cycle.
- **Return to IDLE:** the block is back in IDLE one cycle after `done`. Minimum request-to-request spacing is n+2 cycles.
- **Examples:**
  - `STEP`=1, `amount`=31: done after 32 cycles.
  - `STEP`=4, `amount`=31: n = 8, done after 9 cycles.
  - `amount`=0: done after 1 cycle.
- **`result` stability:** `result` changes only on SHIFT edges and on the accept edge.

## Test plan

- SRA, `STEP`=1, `operand`=0x80000000, `amount`=4: `busy` high for 5 cycles, `done` in cycle 5 after request, `result`=0xF8000000, `ready` back high the following cycle.
- SLL, `STEP`=4, `operand`=0x00000001, `amount`=31: `done` exactly 9 cycles after request, `result`=0x80000000. Also check `amount`=0 with `operand`=0x12345678: `done` 1 cycle later, `result`=0x12345678.
- SRL, `STEP`=2, `operand`=0xFFFFFFFF, `amount`=31: `result`=0x00000001, no sign fill. Repeat with `op`=10: identical result.
- Back-to-back: assert `start` continuously with new operands. Each request is accepted only in IDLE, `start` pulses during SHIFT/DONE produce no extra `done`, and the spacing is n+2 cycles.
- `flush` asserted 2 cycles into an SRA by 20 (`STEP`=1): no `done` pulse, `ready`=1 the next cycle, and a new request is accepted immediately afterwards and completes correctly.
- `rst` asserted mid-SHIFT together with `flush` and `start`: after the edge, `ready`=1, `busy`=0, `done`=0, `result`=0. No `done` appears for the aborted operation.
